// File: rtl/if_pkg.sv
// Shared fetch-side types: the IF/ID pair layout and the nop encoding.
package if_pkg;
   localparam int IA_W = 32;
   localparam int ID_W = 32;

   typedef struct packed {
      logic [IA_W-1:0] pc;
      logic [ID_W-1:0] inst;
   } fetch_entry_t;

   localparam logic [ID_W-1:0] NOP_INST = '0;
endpackage

// File: rtl/if_id_queue_if.sv
// IF/ID queue handshake bundle; the queue is the slave, the fetch/decode side the master.
interface if_id_queue_if
   import if_pkg::*;
#(
   parameter int ADDR_W = IA_W,
   parameter int DATA_W = ID_W,
   parameter int CNT_W  = 3
);
   logic              i_if_valid;
   logic [ADDR_W-1:0] i_if_pc;
   logic [DATA_W-1:0] i_if_inst;
   logic              o_if_ready;
   logic              o_id_valid;
   logic [ADDR_W-1:0] o_id_pc;
   logic [DATA_W-1:0] o_id_inst;
   logic              i_id_ready;
   logic              i_flush;
   logic [CNT_W-1:0]  o_count;
   logic              o_full;

   modport slave (
      input  i_if_valid, i_if_pc, i_if_inst, i_id_ready, i_flush,
      output o_if_ready, o_id_valid, o_id_pc, o_id_inst, o_count, o_full
   );

   modport master (
      output i_if_valid, i_if_pc, i_if_inst, i_id_ready, i_flush,
      input  o_if_ready, o_id_valid, o_id_pc, o_id_inst, o_count, o_full
   );
endinterface

// File: rtl/fq_ptr_ctrl.sv
// Pointer, occupancy and flush control for the IF/ID queue.
module fq_ptr_ctrl #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push_req,
   input  logic             i_pop_req,
   input  logic             i_flush,
   output logic             o_wr_en,
   output logic [PTR_W-1:0] o_wr_ptr,
   output logic [PTR_W-1:0] o_rd_ptr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);
   logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0] count_d, count_q;
   logic             rd_en;

   // Full/empty come from the count so pointer equality never needs disambiguating.
   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_wr_en = i_push_req && !o_full && !i_flush;
   assign rd_en   = i_pop_req && !o_empty && !i_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (o_wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_en)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({o_wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_wr_ptr = wr_ptr_q;
   assign o_rd_ptr = rd_ptr_q;
   assign o_count  = count_q;
endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: storage array, fall-through head mux and nop forcing when empty.
module if_id_queue
   import if_pkg::*;
#(
   parameter int ADDR_W = IA_W,
   parameter int DATA_W = ID_W,
   parameter int DEPTH  = 4
) (
   input logic          i_clk,
   input logic          i_rst,
   if_id_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [DATA_W-1:0] inst_mem_q [DEPTH];
   logic              wr_en;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full, empty;
   logic [ADDR_W-1:0] head_pc;
   logic [DATA_W-1:0] head_inst;

   fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push_req (bus.i_if_valid),
      .i_pop_req  (bus.i_id_ready),
      .i_flush    (bus.i_flush),
      .o_wr_en    (wr_en),
      .o_wr_ptr   (wr_ptr),
      .o_rd_ptr   (rd_ptr),
      .o_count    (count),
      .o_full     (full),
      .o_empty    (empty)
   );

   // Storage carries no reset; stale slots are masked by the empty check below.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         pc_mem_q[wr_ptr]   <= bus.i_if_pc;
         inst_mem_q[wr_ptr] <= bus.i_if_inst;
      end
   end

   always_comb begin
      head_pc   = '0;
      head_inst = DATA_W'(NOP_INST);
      if (!empty) begin
         head_pc   = pc_mem_q[rd_ptr];
         head_inst = inst_mem_q[rd_ptr];
      end
   end

   assign bus.o_if_ready = !full;
   assign bus.o_id_valid = !empty;
   assign bus.o_id_pc    = head_pc;
   assign bus.o_id_inst  = head_inst;
   assign bus.o_count    = count;
   assign bus.o_full     = full;
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: fill/drain, streaming, flush and async reset.
module tb_if_id_queue;
   import if_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   if_id_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) bus ();

   if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int m_cnt = 0;
   logic [31:0] sb_pc[$], sb_inst[$];
   logic [31:0] exp_pc[$], exp_inst[$];
   logic [31:0] obs_pc[$], obs_inst[$];

   // One clock: the bench model decides push/pop, records the consumed head, advances.
   task automatic tick();
      bit push, pop;
      push = bus.i_if_valid && !bus.i_flush && (m_cnt < DEPTH);
      pop  = bus.i_id_ready && !bus.i_flush && (m_cnt > 0);
      if (pop) begin
         obs_pc.push_back(bus.o_id_pc);
         obs_inst.push_back(bus.o_id_inst);
      end
      @(posedge clk);
      if (bus.i_flush) begin
         sb_pc.delete();
         sb_inst.delete();
         m_cnt = 0;
      end else begin
         if (pop) begin
            exp_pc.push_back(sb_pc.pop_front());
            exp_inst.push_back(sb_inst.pop_front());
            m_cnt--;
         end
         if (push) begin
            sb_pc.push_back(bus.i_if_pc);
            sb_inst.push_back(bus.i_if_inst);
            m_cnt++;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_if_valid = 1'b0;
      bus.i_if_pc    = '0;
      bus.i_if_inst  = '0;
      bus.i_id_ready = 1'b0;
      bus.i_flush    = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      n_vec++; if (bus.o_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.o_id_valid); end
      n_vec++; if (bus.o_id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", bus.o_id_pc); end
      n_vec++; if (bus.o_id_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", bus.o_id_inst); end
      n_vec++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.o_count); end
      n_vec++; if (bus.o_if_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.o_if_ready); end
      n_vec++; if (bus.o_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", bus.o_full); end
      rst = 1'b0;
      tick();
      n_vec++; if (bus.o_id_valid !== 1'b0 || bus.o_count !== 3'd0) begin
         n_err++; $display("FAIL idle: got valid=%b count=%0d want 0/0", bus.o_id_valid, bus.o_count);
      end
   endtask

   task automatic test_fill_full();
      bus.i_id_ready = 1'b0;
      bus.i_if_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.i_if_pc   = 32'h100 + 32'(4 * i);
         bus.i_if_inst = 32'hA0 + 32'(i);
         tick();
         if (i == 0) begin
            n_vec++; if (bus.o_id_valid !== 1'b1 || bus.o_id_pc !== 32'h100) begin
               n_err++; $display("FAIL first_latency: got valid=%b pc=%h want 1/00000100", bus.o_id_valid, bus.o_id_pc);
            end
         end
      end
      n_vec++; if (bus.o_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", bus.o_full); end
      n_vec++; if (bus.o_if_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.o_if_ready); end
      bus.i_if_pc   = 32'h110;
      bus.i_if_inst = 32'hA4;
      tick();
      n_vec++; if (bus.o_count !== 3'(m_cnt) || m_cnt != 4) begin
         n_err++; $display("FAIL push_when_full: got count=%0d want 4", bus.o_count);
      end
      bus.i_if_valid = 1'b0;
   endtask

   task automatic test_drain();
      bus.i_id_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_vec++; if (obs_pc.size() != exp_pc.size() || exp_pc.size() != 4) begin
         n_err++; $display("FAIL drain_len: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         logic [31:0] ep, ei, op, oi;
         ep = exp_pc.pop_front(); ei = exp_inst.pop_front();
         op = obs_pc.pop_front(); oi = obs_inst.pop_front();
         n_vec++; if (op !== ep || oi !== ei) begin
            n_err++; $display("FAIL drain_order: got %h/%h want %h/%h", op, oi, ep, ei);
         end
      end
      n_vec++; if (bus.o_count !== 3'd0 || bus.o_id_inst !== 32'h0 || bus.o_id_pc !== 32'h0) begin
         n_err++; $display("FAIL drain_empty: got count=%0d pc=%h inst=%h want 0/0/0", bus.o_count, bus.o_id_pc, bus.o_id_inst);
      end
      tick();
      n_vec++; if (bus.o_count !== 3'd0 || bus.o_id_valid !== 1'b0) begin
         n_err++; $display("FAIL pop_when_empty: got count=%0d valid=%b want 0/0", bus.o_count, bus.o_id_valid);
      end
      bus.i_id_ready = 1'b0;
   endtask

   task automatic test_stream();
      bus.i_id_ready = 1'b0;
      bus.i_if_valid = 1'b1;
      bus.i_if_pc    = 32'h300;
      bus.i_if_inst  = 32'hC00;
      tick();
      bus.i_id_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         bus.i_if_pc   = 32'h300 + 32'(4 * i);
         bus.i_if_inst = 32'hC00 + 32'(i);
         tick();
         n_vec++; if (bus.o_count !== 3'd1 || bus.o_id_pc !== 32'h300 + 32'(4 * i)) begin
            n_err++; $display("FAIL stream_%0d: got count=%0d pc=%h want 1/%h", i, bus.o_count, bus.o_id_pc, 32'h300 + 32'(4 * i));
         end
      end
      bus.i_if_valid = 1'b0;
      tick();
      bus.i_id_ready = 1'b0;
      n_vec++; if (obs_pc.size() != exp_pc.size() || exp_pc.size() != 11) begin
         n_err++; $display("FAIL stream_len: got %0d want %0d", obs_pc.size(), exp_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         logic [31:0] ep, ei, op, oi;
         ep = exp_pc.pop_front(); ei = exp_inst.pop_front();
         op = obs_pc.pop_front(); oi = obs_inst.pop_front();
         n_vec++; if (op !== ep || oi !== ei) begin
            n_err++; $display("FAIL stream_order: got %h/%h want %h/%h", op, oi, ep, ei);
         end
      end
   endtask

   task automatic test_flush();
      bus.i_id_ready = 1'b0;
      bus.i_if_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.i_if_pc   = 32'h400 + 32'(4 * i);
         bus.i_if_inst = 32'hD0 + 32'(i);
         tick();
      end
      n_vec++; if (bus.o_count !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", bus.o_count); end
      bus.i_if_pc    = 32'h40C;
      bus.i_if_inst  = 32'hD3;
      bus.i_id_ready = 1'b1;
      bus.i_flush    = 1'b1;
      tick();
      n_vec++; if (bus.o_count !== 3'd0 || bus.o_id_valid !== 1'b0 || bus.o_if_ready !== 1'b1 || bus.o_id_pc !== 32'h0) begin
         n_err++; $display("FAIL flush_clear: got count=%0d valid=%b ready=%b pc=%h want 0/0/1/0",
                           bus.o_count, bus.o_id_valid, bus.o_if_ready, bus.o_id_pc);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL flush_hold: got %0d want 0", bus.o_count); end
      end
      bus.i_flush    = 1'b0;
      bus.i_id_ready = 1'b0;
      bus.i_if_pc    = 32'h500;
      bus.i_if_inst  = 32'hE0;
      tick();
      bus.i_if_valid = 1'b0;
      n_vec++; if (bus.o_id_pc !== 32'h500 || bus.o_id_inst !== 32'hE0 || bus.o_count !== 3'd1) begin
         n_err++; $display("FAIL flush_after: got pc=%h inst=%h count=%0d want 00000500/000000e0/1",
                           bus.o_id_pc, bus.o_id_inst, bus.o_count);
      end
      bus.i_id_ready = 1'b1;
      tick();
      bus.i_id_ready = 1'b0;
      n_vec++; if (obs_pc.size() != 1 || exp_pc.size() != 1) begin
         n_err++; $display("FAIL flush_len: got %0d want 1", obs_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         logic [31:0] ep, op;
         ep = exp_pc.pop_front(); void'(exp_inst.pop_front());
         op = obs_pc.pop_front(); void'(obs_inst.pop_front());
         n_vec++; if (op !== ep) begin n_err++; $display("FAIL flush_order: got %h want %h", op, ep); end
      end
   endtask

   task automatic test_async_reset();
      bus.i_id_ready = 1'b0;
      bus.i_if_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.i_if_pc   = 32'h600 + 32'(4 * i);
         bus.i_if_inst = 32'hF0 + 32'(i);
         tick();
      end
      bus.i_if_valid = 1'b0;
      n_vec++; if (bus.o_count !== 3'd2) begin n_err++; $display("FAIL arst_pre: got %0d want 2", bus.o_count); end
      #2 rst = 1'b1;
      #1;
      n_vec++; if (bus.o_count !== 3'd0 || bus.o_id_valid !== 1'b0 || bus.o_id_pc !== 32'h0 || bus.o_id_inst !== 32'h0) begin
         n_err++; $display("FAIL arst_clear: got count=%0d valid=%b pc=%h inst=%h want 0/0/0/0",
                           bus.o_count, bus.o_id_valid, bus.o_id_pc, bus.o_id_inst);
      end
      sb_pc.delete(); sb_inst.delete(); m_cnt = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.i_if_valid = 1'b1;
      bus.i_if_pc    = 32'h200;
      bus.i_if_inst  = 32'hB0;
      tick();
      bus.i_if_valid = 1'b0;
      n_vec++; if (bus.o_id_valid !== 1'b1 || bus.o_id_pc !== 32'h200 || bus.o_count !== 3'd1) begin
         n_err++; $display("FAIL arst_push: got valid=%b pc=%h count=%0d want 1/00000200/1", bus.o_id_valid, bus.o_id_pc, bus.o_count);
      end
      bus.i_id_ready = 1'b1;
      tick();
      bus.i_id_ready = 1'b0;
      n_vec++; if (obs_pc.size() != 1 || exp_pc.size() != 1) begin
         n_err++; $display("FAIL arst_len: got %0d want 1", obs_pc.size());
      end
      while (exp_pc.size() > 0 && obs_pc.size() > 0) begin
         logic [31:0] ep, ei, op, oi;
         ep = exp_pc.pop_front(); ei = exp_inst.pop_front();
         op = obs_pc.pop_front(); oi = obs_inst.pop_front();
         n_vec++; if (op !== ep || oi !== ei) begin
            n_err++; $display("FAIL arst_order: got %h/%h want %h/%h", op, oi, ep, ei);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_fill_full();
      test_drain();
      test_stream();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
